// File: rtl/dec_pkg.sv
// Shared types and default sizes for the decrementing counter slice.
package dec_pkg;
   localparam int DEC_WIDTH_DEF  = 20;
   localparam int DEC_STEP_W_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_RUN,
      ST_HOLD,
      ST_DONE
   } dec_state_e;
endpackage

// File: rtl/dec_step.sv
// Subtract-with-borrow datapath: diff = a - b mod 2^WIDTH, bout set when b > a.
module dec_step
   import dec_pkg::*;
#(
   parameter int WIDTH = DEC_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);
   logic [WIDTH:0] full;

   assign full = {1'b0, a} - {1'b0, b};
   assign diff = full[WIDTH-1:0];
   assign bout = full[WIDTH];
endmodule

// File: rtl/dec_counter.sv
// Load/start/pause/abort down-counter with saturate or wrap underflow.
// Optional feature: DEC_COUNTER_AUTORELOAD_EN reloads the last loaded value at terminal count.
module dec_counter
   import dec_pkg::*;
#(
   parameter int WIDTH  = DEC_WIDTH_DEF,
   parameter int STEP_W = DEC_STEP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [WIDTH-1:0]  load_value,
   input  logic [STEP_W-1:0] step,
   input  logic              mode_wrap,
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              tc_pulse,
   output logic              borrow
);
   dec_state_e       state, state_nx;
   logic [WIDTH-1:0] count_nx, step_ext, sub_diff, dec_cnt;
   logic             sub_bout, dec_tc, busy_nx, tc_nx, borrow_nx;
`ifdef DEC_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_nx;
   logic             reload_pend, pend_nx;
`endif

   function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] diff,
                                                input logic bout, input logic wrap);
      if (bout && !wrap)
         sat_sub = '0;
      else
         sat_sub = diff;
   endfunction

   assign step_ext = WIDTH'(step);

   dec_step #(.WIDTH(WIDTH)) u_step (
      .a    (count),
      .b    (step_ext),
      .diff (sub_diff),
      .bout (sub_bout)
   );

   assign dec_cnt    = sat_sub(sub_diff, sub_bout, mode_wrap);
   assign dec_tc     = (dec_cnt == '0);
   assign load_ready = (state == ST_IDLE) || (state == ST_ARMED) || (state == ST_DONE);

   always_comb begin
      state_nx  = state;
      count_nx  = count;
      tc_nx     = 1'b0;
      borrow_nx = 1'b0;
`ifdef DEC_COUNTER_AUTORELOAD_EN
      reload_nx = reload_q;
      pend_nx   = reload_pend;
`endif
      if (abort) begin
         state_nx = ST_IDLE;
`ifdef DEC_COUNTER_AUTORELOAD_EN
         pend_nx  = 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ARMED: begin
               // A load in ARMED wins over a coincident start.
               if (load_valid) begin
                  count_nx = load_value;
                  state_nx = ST_ARMED;
`ifdef DEC_COUNTER_AUTORELOAD_EN
                  reload_nx = load_value;
                  pend_nx   = 1'b0;
`endif
               end else if (start && (state == ST_ARMED)) begin
                  state_nx = ST_RUN;
               end
            end
            ST_RUN, ST_HOLD: begin
               // Releasing pause decrements in the same cycle it returns to RUN.
               if (pause) begin
                  state_nx = ST_HOLD;
               end else begin
                  state_nx = ST_RUN;
`ifdef DEC_COUNTER_AUTORELOAD_EN
                  if (reload_pend) begin
                     count_nx = reload_q;
                     pend_nx  = 1'b0;
                  end else begin
                     count_nx  = dec_cnt;
                     borrow_nx = sub_bout & mode_wrap;
                     tc_nx     = dec_tc;
                     pend_nx   = dec_tc;
                  end
`else
                  count_nx  = dec_cnt;
                  borrow_nx = sub_bout & mode_wrap;
                  tc_nx     = dec_tc;
                  if (dec_tc)
                     state_nx = ST_DONE;
`endif
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
      busy_nx = (state_nx == ST_RUN) || (state_nx == ST_HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         count    <= '0;
         busy     <= 1'b0;
         tc_pulse <= 1'b0;
         borrow   <= 1'b0;
`ifdef DEC_COUNTER_AUTORELOAD_EN
         reload_pend <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         count    <= count_nx;
         busy     <= busy_nx;
         tc_pulse <= tc_nx;
         borrow   <= borrow_nx;
`ifdef DEC_COUNTER_AUTORELOAD_EN
         reload_pend <= pend_nx;
`endif
      end
   end

`ifdef DEC_COUNTER_AUTORELOAD_EN
   always_ff @(posedge clk) begin
      reload_q <= reload_nx;
   end
`endif
endmodule

// File: tb/tb_dec_counter.sv
// Scoreboard bench for dec_counter: stimulus queues per-cycle expectations, a negedge monitor compares.
module tb_dec_counter;
   logic        clk, rst_n, load_valid, load_ready, mode_wrap, start, pause, abort;
   logic [19:0] load_value, count;
   logic [3:0]  step;
   logic        busy, tc_pulse, borrow;

   dec_counter #(.WIDTH(20), .STEP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
      .load_value(load_value), .step(step), .mode_wrap(mode_wrap), .start(start),
      .pause(pause), .abort(abort), .count(count), .busy(busy), .tc_pulse(tc_pulse),
      .borrow(borrow)
   );

   typedef struct {
      int          due;
      logic [19:0] cnt;
      logic        bsy, tc, br, rdy;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         check({e.tag, ".count"},      32'(count),      32'(e.cnt));
         check({e.tag, ".busy"},       32'(busy),       32'(e.bsy));
         check({e.tag, ".tc_pulse"},   32'(tc_pulse),   32'(e.tc));
         check({e.tag, ".borrow"},     32'(borrow),     32'(e.br));
         check({e.tag, ".load_ready"}, 32'(load_ready), 32'(e.rdy));
      end
   end

   // Inputs are set by the caller; this records what the outputs must be after the next edge.
   task automatic tick(input string tag, input logic [19:0] c, input logic b,
                       input logic t, input logic br, input logic r);
      exp_t e;
      e.due = cyc + 1; e.cnt = c; e.bsy = b; e.tc = t; e.br = br; e.rdy = r; e.tag = tag;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1; load_valid = 0; load_value = '0; step = '0; mode_wrap = 0;
      start = 0; pause = 0; abort = 0;
      #2 rst_n = 1'b0;
      #1;
      check("reset.count",    32'(count),    0);
      check("reset.busy",     32'(busy),     0);
      check("reset.tc_pulse", 32'(tc_pulse), 0);
      check("reset.borrow",   32'(borrow),   0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset.load_ready", 32'(load_ready), 1);

      // load 10, step 3, saturate mode
      load_valid = 1; load_value = 20'd10; step = 4'd3;
      tick("t1_load", 10, 0, 0, 0, 1);
      load_valid = 0; start = 1;
      tick("t1_start", 10, 1, 0, 0, 0);
      start = 0;
      tick("t1_c7", 7, 1, 0, 0, 0);
      tick("t1_c4", 4, 1, 0, 0, 0);
      tick("t1_c1", 1, 1, 0, 0, 0);
`ifdef DEC_COUNTER_AUTORELOAD_EN
      tick("t1_tc", 0, 1, 1, 0, 0);
      tick("t1_reload", 10, 1, 0, 0, 0);
      abort = 1;
      tick("t1_abort", 10, 0, 0, 0, 1);
      abort = 0;
      // load 4, step 2 with auto-reload
      load_valid = 1; load_value = 20'd4; step = 4'd2;
      tick("ar_load", 4, 0, 0, 0, 1);
      load_valid = 0; start = 1;
      tick("ar_start", 4, 1, 0, 0, 0);
      start = 0;
      tick("ar_c2a", 2, 1, 0, 0, 0);
      tick("ar_tc1", 0, 1, 1, 0, 0);
      tick("ar_r4a", 4, 1, 0, 0, 0);
      tick("ar_c2b", 2, 1, 0, 0, 0);
      tick("ar_tc2", 0, 1, 1, 0, 0);
      tick("ar_r4b", 4, 1, 0, 0, 0);
      abort = 1;
      tick("ar_abort", 4, 0, 0, 0, 1);
      abort = 0;
`else
      tick("t1_tc", 0, 0, 1, 0, 1);
      start = 1;
      tick("t1_done_start", 0, 0, 0, 0, 1);
      start = 0;
`endif

      // load 2, step 5, wrap mode underflow
      load_valid = 1; load_value = 20'd2; step = 4'd5; mode_wrap = 1;
      tick("t2_load", 2, 0, 0, 0, 1);
      load_valid = 0; start = 1;
      tick("t2_start", 2, 1, 0, 0, 0);
      start = 0;
      tick("t2_wrap", 20'hFFFFD, 1, 0, 1, 0);
      step = 4'd0;
      tick("t2_step0a", 20'hFFFFD, 1, 0, 0, 0);
      tick("t2_step0b", 20'hFFFFD, 1, 0, 0, 0);
      abort = 1;
      tick("t2_abort", 20'hFFFFD, 0, 0, 0, 1);
      abort = 0; mode_wrap = 0;

      // load 5, step 7, saturate to zero
      load_valid = 1; load_value = 20'd5; step = 4'd7;
      tick("t3_load", 5, 0, 0, 0, 1);
      load_valid = 0; start = 1;
      tick("t3_start", 5, 1, 0, 0, 0);
      start = 0;
`ifdef DEC_COUNTER_AUTORELOAD_EN
      tick("t3_sat", 0, 1, 1, 0, 0);
      tick("t3_reload", 5, 1, 0, 0, 0);
      abort = 1;
      tick("t3_abort", 5, 0, 0, 0, 1);
      abort = 0;
`else
      tick("t3_sat", 0, 0, 1, 0, 1);
`endif

      // load 8, step 1, pause for three cycles at 5, then abort at 3
      load_valid = 1; load_value = 20'd8; step = 4'd1;
      tick("t4_load", 8, 0, 0, 0, 1);
      load_valid = 0; start = 1;
      tick("t4_start", 8, 1, 0, 0, 0);
      start = 0;
      tick("t4_c7", 7, 1, 0, 0, 0);
      tick("t4_c6", 6, 1, 0, 0, 0);
      tick("t4_c5", 5, 1, 0, 0, 0);
      pause = 1;
      tick("t4_hold1", 5, 1, 0, 0, 0);
      tick("t4_hold2", 5, 1, 0, 0, 0);
      tick("t4_hold3", 5, 1, 0, 0, 0);
      pause = 0;
      tick("t4_c4", 4, 1, 0, 0, 0);
      tick("t4_c3", 3, 1, 0, 0, 0);
      abort = 1;
      tick("t4_abort", 3, 0, 0, 0, 1);
      load_valid = 1; load_value = 20'd9; start = 1;
      tick("t4_abort_prio", 3, 0, 0, 0, 1);
      abort = 0; load_valid = 0;
      tick("t4_idle_start", 3, 0, 0, 0, 1);
      start = 0;

      // load then load+start in ARMED: load wins
      load_valid = 1; load_value = 20'd9;
      tick("t5_load9", 9, 0, 0, 0, 1);
      load_value = 20'd6; start = 1;
      tick("t5_load6_start", 6, 0, 0, 0, 1);
      load_valid = 0; start = 0;
      tick("t5_armed", 6, 0, 0, 0, 1);
      start = 1;
      tick("t5_start", 6, 1, 0, 0, 0);
      start = 0; step = 4'd5;
      tick("t5_c1", 1, 1, 0, 0, 0);

      // asynchronous reset mid-RUN, one step before terminal count
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid.count", 32'(count), 0);
      check("rst_mid.busy",  32'(busy),  0);
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_mid.tc_pulse", 32'(tc_pulse), 0);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_rel.load_ready", 32'(load_ready), 1);
      check("rst_rel.tc_pulse",   32'(tc_pulse),   0);
      load_valid = 1; load_value = 20'd3;
      tick("t6_load", 3, 0, 0, 0, 1);
      load_valid = 0;

      @(negedge clk); #1;
      check("scoreboard.drained", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
